// File: rtl/bist_datapath_pkg.sv
// Shared types, constants and address helpers for the BIST datapath and the
// March-test control FSM that drives it.
package bist_pkg;

  localparam int FAIL_CNT_W = 8;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

  // One command word from control; the field order is the decode order both sides agree on.
  typedef struct packed {
    logic enable;
    logic up_down;
    logic rst_adr;
    logic pr_res_adr;
    logic wr_en;
    logic read_en;
    logic data_bit;
  } bist_cmd_t;

  localparam int CMD_W = $bits(bist_cmd_t);

  function automatic logic [31:0] start_addr(input logic up_down, input int unsigned addr_w);
    return up_down ? 32'd0 : ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] term_addr(input logic up_down, input int unsigned addr_w);
    return start_addr(!up_down, addr_w);
  endfunction

endpackage

// File: rtl/bist_datapath_if.sv
// Memory-under-test bus between the BIST datapath (master) and the memory (slave).
interface bist_datapath_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              mem_re;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/bist_datapath_cmp_pipe.sv
// Delays the expected word and its address by the memory read latency so they
// line up with returning read data, then flags a mismatch.
module bist_cmp_pipe
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              mismatch_o,
  output logic [ADDR_W-1:0] mis_addr_o
);

  logic [DATA_W-1:0] exp_q  [RD_LAT];
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;

  // A clear drops every tag in flight, including one being pushed this cycle.
  always_comb begin
    vld_d = '0;
    if (!clear_i) begin
      vld_d[0] = push_i;
      for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    exp_q[0]  <= exp_i;
    addr_q[0] <= addr_i;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_q[i]  <= exp_q[i-1];
      addr_q[i] <= addr_q[i-1];
    end
  end

  assign mismatch_o = vld_q[RD_LAT-1] && (exp_q[RD_LAT-1] != rdata_i);
  assign mis_addr_o = addr_q[RD_LAT-1];

endmodule

// File: rtl/bist_datapath.sv
// BIST address/data datapath: up/down address counter with wrap pulse, background
// write data, and read-compare result registers (sticky fail, first-fail address, count).
module bist_datapath
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  rst_adr,
  input  logic                  pr_res_adr,
  input  logic                  wr_en,
  input  logic                  read_en,
  input  logic                  data_bit,
  bist_datapath_if.master       mem,
  output logic                  c_out,
  output logic                  fail,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  bist_cmd_t             cmd;
  logic [ADDR_W-1:0]     start_a, term_a;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  c_out_q, c_out_d;
  logic                  fail_q, fail_d;
  logic [ADDR_W-1:0]     fail_addr_q, fail_addr_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic                  mismatch;
  logic [ADDR_W-1:0]     mis_addr;

  assign cmd = '{enable: enable, up_down: up_down, rst_adr: rst_adr, pr_res_adr: pr_res_adr,
                 wr_en: wr_en, read_en: read_en, data_bit: data_bit};

  assign start_a = ADDR_W'(start_addr(cmd.up_down, ADDR_W));
  assign term_a  = ADDR_W'(term_addr(cmd.up_down, ADDR_W));

  // Stepping off the terminal address wraps to start naturally via modulo arithmetic.
  always_comb begin
    addr_d = addr_q;
    if (cmd.rst_adr)     addr_d = start_a;
    else if (cmd.enable) addr_d = cmd.up_down ? addr_q + 1'b1 : addr_q - 1'b1;
  end

  assign c_out_d = cmd.enable && !cmd.rst_adr && (addr_q == term_a);

  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_cnt_d  = fail_cnt_q;
    if (cmd.pr_res_adr) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_cnt_d  = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = mis_addr;
      if (fail_cnt_q != FAIL_CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      c_out_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      c_out_q     <= c_out_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  bist_cmp_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_i     (cmd.read_en),
    .clear_i    (cmd.pr_res_adr),
    .exp_i      ({DATA_W{cmd.data_bit}}),
    .addr_i     (addr_q),
    .rdata_i    (mem.mem_rdata),
    .mismatch_o (mismatch),
    .mis_addr_o (mis_addr)
  );

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = {DATA_W{cmd.data_bit}};
  assign mem.mem_we    = cmd.wr_en;
  assign mem.mem_re    = cmd.read_en;

  assign c_out     = c_out_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_bist_datapath.sv
// Self-checking bench for bist_datapath: directed March-style scenarios plus a
// randomized run, all checked against a cycle-level behavioural model.
module tb_bist_datapath;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst, enable, up_down, rst_adr, pr_res_adr, wr_en, read_en, data_bit;
  logic c_out, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [7:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bist_datapath_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  bist_datapath #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .up_down    (up_down),
    .rst_adr    (rst_adr),
    .pr_res_adr (pr_res_adr),
    .wr_en      (wr_en),
    .read_en    (read_en),
    .data_bit   (data_bit),
    .mem        (mem_if),
    .c_out      (c_out),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // Memory under test; flip[] injects faults into returned read data.
  bit [7:0] mem_arr [DEPTH];
  bit [7:0] flip    [DEPTH];
  bit [7:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_if.mem_re ? (mem_arr[mem_if.mem_addr] ^ flip[mem_if.mem_addr]) : 8'h00;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_if.mem_we) mem_arr[mem_if.mem_addr] <= mem_if.mem_wdata;
  end

  assign mem_if.mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model: reads are resolved at issue time and retire RD_LAT edges later.
  typedef struct { int due; logic [3:0] addr; bit bad; } pend_t;
  pend_t      pend [$];
  bit [7:0]   m_mem [DEPTH];
  logic [3:0] m_addr = '0;
  logic       m_cout = 1'b0;
  logic       m_fail = 1'b0;
  logic [3:0] m_faddr = '0;
  int         m_cnt = 0;
  int         cyc = 0;

  task automatic applyStimulus(input logic en, ud, ra, pr, we, re, db, rs);
    logic [3:0] a0;
    logic [3:0] start;
    logic [3:0] term;
    pend_t e;
    enable = en; up_down = ud; rst_adr = ra; pr_res_adr = pr;
    wr_en = we; read_en = re; data_bit = db; rst = rs;
    @(posedge clk);
    a0    = m_addr;
    start = ud ? 4'd0 : 4'(DEPTH - 1);
    term  = ud ? 4'(DEPTH - 1) : 4'd0;
    if (rs) begin
      m_addr = '0; m_cout = 1'b0; m_fail = 1'b0; m_faddr = '0; m_cnt = 0;
      pend.delete();
    end else begin
      if (pr) begin
        m_fail = 1'b0; m_faddr = '0; m_cnt = 0;
        pend.delete();
      end else begin
        while (pend.size() > 0 && pend[0].due == cyc) begin
          e = pend.pop_front();
          if (e.bad) begin
            if (!m_fail) m_faddr = e.addr;
            m_fail = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        end
        if (re) pend.push_back('{due: cyc + RD_LAT, addr: a0,
                                 bad: ((m_mem[a0] ^ flip[a0]) != {8{db}})});
      end
      m_cout = en && !ra && (a0 == term);
      if (ra)      m_addr = start;
      else if (en) m_addr = ud ? a0 + 4'd1 : a0 - 4'd1;
    end
    if (we) m_mem[a0] = {8{db}};
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    n_checks++; if (mem_if.mem_addr !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0h want 0", mem_if.mem_addr); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cout: got %b want 0", c_out); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fail: got %b want 0", fail); end
    n_checks++; if (fail_addr !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_fail_addr: got %0h want 0", fail_addr); end
    n_checks++; if (fail_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
  endtask

  task automatic test_sweep_up();
    int pulses = 0;
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    n_checks++; if (mem_if.mem_addr !== 4'd0) begin n_fail++; $display("[TB] FAIL up_start: got %0h want 0", mem_if.mem_addr); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
      n_checks++; if (mem_if.mem_addr !== m_addr) begin n_fail++; $display("[TB] FAIL up_addr[%0d]: got %0h want %0h", i, mem_if.mem_addr, m_addr); end
      n_checks++; if (c_out !== m_cout) begin n_fail++; $display("[TB] FAIL up_cout[%0d]: got %b want %b", i, c_out, m_cout); end
      if (c_out === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL up_pulses: got %0d want 1", pulses); end
    n_checks++; if (c_out !== 1'b1 || mem_if.mem_addr !== 4'd0) begin n_fail++; $display("[TB] FAIL up_wrap: got cout=%b addr=%0h want 1/0", c_out, mem_if.mem_addr); end
  endtask

  task automatic test_sweep_down();
    int pulses = 0;
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (mem_if.mem_addr !== 4'hF) begin n_fail++; $display("[TB] FAIL down_start: got %0h want f", mem_if.mem_addr); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (mem_if.mem_addr !== m_addr) begin n_fail++; $display("[TB] FAIL down_addr[%0d]: got %0h want %0h", i, mem_if.mem_addr, m_addr); end
      n_checks++; if (c_out !== m_cout) begin n_fail++; $display("[TB] FAIL down_cout[%0d]: got %b want %b", i, c_out, m_cout); end
      if (c_out === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1 || mem_if.mem_addr !== 4'hF) begin n_fail++; $display("[TB] FAIL down_wrap: got pulses=%0d addr=%0h want 1/f", pulses, mem_if.mem_addr); end
    repeat (DEPTH - 1) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (mem_if.mem_addr !== 4'h0) begin n_fail++; $display("[TB] FAIL down_terminal: got %0h want 0", mem_if.mem_addr); end
    // rst_adr wins over enable even at the terminal address
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (mem_if.mem_addr !== 4'hF) begin n_fail++; $display("[TB] FAIL down_rstadr_en_addr: got %0h want f", mem_if.mem_addr); end
    n_checks++; if (c_out !== 1'b0) begin n_fail++; $display("[TB] FAIL down_rstadr_en_cout: got %b want 0", c_out); end
  endtask

  task automatic test_compare_pass();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (5) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 0);
    n_checks++; if (mem_if.mem_wdata !== 8'hFF || mem_if.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_wdata: got %0h we=%b want ff/1", mem_if.mem_wdata, mem_if.mem_we); end
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0);
    n_checks++; if (mem_if.mem_re !== 1'b1 || mem_if.mem_addr !== 4'd5) begin n_fail++; $display("[TB] FAIL pass_re: got re=%b addr=%0h want 1/5", mem_if.mem_re, mem_if.mem_addr); end
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_fail: got %b want 0", fail); end
    n_checks++; if (fail_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL pass_cnt: got %0d want 0", fail_cnt); end
  endtask

  task automatic test_compare_fail();
    flip[5] = 8'h08;
    flip[9] = 8'hFF;
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (DEPTH) applyStimulus(1, 1, 0, 0, 1, 0, 1, 0);
    repeat (5) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("[TB] FAIL fail_early: got %b want 0", fail); end
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    n_checks++; if (fail !== 1'b1) begin n_fail++; $display("[TB] FAIL fail_latency: got %b want 1", fail); end
    n_checks++; if (fail_addr !== 4'd5 || fail_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL fail_first: got addr=%0h cnt=%0d want 5/1", fail_addr, fail_cnt); end
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    n_checks++; if (fail_addr !== 4'd5) begin n_fail++; $display("[TB] FAIL fail_addr_kept: got %0h want 5", fail_addr); end
    n_checks++; if (fail_cnt !== 8'd2 || fail_cnt !== 8'(m_cnt)) begin n_fail++; $display("[TB] FAIL fail_cnt2: got %0d want 2 (model %0d)", fail_cnt, m_cnt); end
    flip[5] = 8'h00;
    flip[9] = 8'h00;
  endtask

  task automatic test_saturate();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
      n_checks++; if (fail_cnt !== 8'(m_cnt)) begin n_fail++; $display("[TB] FAIL sat_cnt[%0d]: got %0d want %0d", i, fail_cnt, m_cnt); end
    end
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fail_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_final: got %0d want 255", fail_cnt); end
  endtask

  task automatic test_clear_inflight();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fail !== 1'b0 || fail_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_inflight: got fail=%b cnt=%0d want 0/0", fail, fail_cnt); end
    // clear lands on the same edge the compare emerges
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fail !== 1'b0 || fail_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_emerging: got fail=%b cnt=%0d want 0/0", fail, fail_cnt); end
    // read issued together with the clear
    applyStimulus(0, 1, 0, 1, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fail_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_same_cycle: got cnt=%0d want 0", fail_cnt); end
  endtask

  task automatic test_rst_mid_sweep();
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fail_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL rst_pre_cnt: got %0d want 1", fail_cnt); end
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (7) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (mem_if.mem_addr !== 4'd7) begin n_fail++; $display("[TB] FAIL rst_pre_addr: got %0h want 7", mem_if.mem_addr); end
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 1);
    n_checks++; if (mem_if.mem_addr !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_mid_addr: got %0h want 0", mem_if.mem_addr); end
    n_checks++; if (fail !== 1'b0 || fail_cnt !== 8'd0 || fail_addr !== 4'd0 || c_out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_results: got fail=%b cnt=%0d addr=%0h cout=%b want all 0", fail, fail_cnt, fail_addr, c_out);
    end
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fail_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_flush: got cnt=%0d want 0", fail_cnt); end
  endtask

  task automatic test_random();
    logic en, ud, ra, pr, we, re, db, rs;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) flip[$urandom_range(DEPTH - 1)] = 8'($urandom_range(255));
      en = ($urandom_range(3) != 0);
      ud = ($urandom_range(7) != 0) ? up_down : 1'($urandom_range(1));
      ra = ($urandom_range(15) == 0);
      pr = ($urandom_range(15) == 0);
      we = 1'($urandom_range(1));
      re = 1'($urandom_range(1));
      db = 1'($urandom_range(1));
      rs = ($urandom_range(63) == 0);
      applyStimulus(en, ud, ra, pr, we, re, db, rs);
      n_checks++; if (mem_if.mem_addr !== m_addr) begin n_fail++; $display("[TB] FAIL rnd_addr[%0d]: got %0h want %0h", i, mem_if.mem_addr, m_addr); end
      n_checks++; if (c_out !== m_cout) begin n_fail++; $display("[TB] FAIL rnd_cout[%0d]: got %b want %b", i, c_out, m_cout); end
      n_checks++; if (fail !== m_fail) begin n_fail++; $display("[TB] FAIL rnd_fail[%0d]: got %b want %b", i, fail, m_fail); end
      n_checks++; if (fail_addr !== m_faddr) begin n_fail++; $display("[TB] FAIL rnd_fail_addr[%0d]: got %0h want %0h", i, fail_addr, m_faddr); end
      n_checks++; if (fail_cnt !== 8'(m_cnt)) begin n_fail++; $display("[TB] FAIL rnd_cnt[%0d]: got %0d want %0d", i, fail_cnt, m_cnt); end
      n_checks++; if (mem_if.mem_we !== we || mem_if.mem_re !== re || mem_if.mem_wdata !== {8{db}}) begin
        n_fail++; $display("[TB] FAIL rnd_strobes[%0d]: got we=%b re=%b wd=%0h want %b/%b/%0h", i, mem_if.mem_we, mem_if.mem_re, mem_if.mem_wdata, we, re, {8{db}});
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; up_down = 1'b1; rst_adr = 1'b0; pr_res_adr = 1'b0;
    wr_en = 1'b0; read_en = 1'b0; data_bit = 1'b0;
    $display("[TB] starting bist_datapath bench");
    test_reset();
    test_sweep_up();
    test_sweep_down();
    test_compare_pass();
    test_compare_fail();
    test_saturate();
    test_clear_inflight();
    test_rst_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
